// File: rtl/stim_pkg.sv
// -----------------------------------------------------------------------------
// stim_pkg
// Shared definitions for the multi-channel ASIC stimulus pulse generator.
//   - Mode encodings for the 2-bit mode field.
//   - FSM state encoding used by stim_pulse_gen.
//   - is_counted_mode(): true for the modes that terminate by themselves.
// -----------------------------------------------------------------------------
package stim_pkg;

    localparam logic [1:0] MODE_CONT   = 2'd0;
    localparam logic [1:0] MODE_BURST  = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;
    localparam logic [1:0] MODE_SQUARE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } stim_state_e;

    // Burst and single-shot sequences end on their own; the others run until disabled.
    function automatic logic is_counted_mode(input logic [1:0] m);
        return (m == MODE_BURST) || (m == MODE_SINGLE);
    endfunction

endpackage

// File: rtl/stim_phase_cnt.sv
// -----------------------------------------------------------------------------
// stim_phase_cnt
// Phase counter for the stimulus generator. Counts 0..period-1 and wraps.
// Ports:
//   clk50, rst_n  clock and asynchronous active-low reset
//   clr           hold the phase at zero (has priority over en)
//   en            advance the phase by one each cycle
//   period        effective period (caller guarantees >= 2)
//   high          effective high time (caller guarantees < period)
//   wrap          phase is at its last value this cycle (en qualified)
//   first         phase is at zero this cycle, i.e. a period begins (en qualified)
//   pulse_raw     raw pulse level, phase < high (en qualified)
// -----------------------------------------------------------------------------
module stim_phase_cnt
    import stim_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk50,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high,
    output logic             wrap,
    output logic             first,
    output logic             pulse_raw
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] phase_r;
    logic             last_s;

    // Last phase of the period; >= keeps the counter bounded if period ever shrinks.
    always_comb begin
        last_s = 1'b0;
        if (phase_r >= (period - CNT_ONE)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Phase register: cleared, advanced or held.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= CNT_ZERO;
        end else if (clr) begin
            phase_r <= CNT_ZERO;
        end else if (en) begin
            if (last_s) begin
                phase_r <= CNT_ZERO;
            end else begin
                phase_r <= phase_r + CNT_ONE;
            end
        end
    end

    // Status flags derived from the current phase.
    always_comb begin
        wrap      = en & last_s;
        first     = en & (phase_r == CNT_ZERO);
        pulse_raw = en & (phase_r < high);
    end

endmodule

// File: rtl/stim_pulse_gen.sv
// -----------------------------------------------------------------------------
// stim_pulse_gen
// Multi-channel programmable pulse generator driving the ASIC stim pins.
// Modes: continuous, counted burst, single shot, 50 % square.
// Ports:
//   clk50, rst_n  50 MHz clock, asynchronous active-low reset
//   stim_en       master enable; low aborts any sequence and forces outputs low
//   start         one-cycle request to begin a sequence (accepted in IDLE only)
//   mode          0 continuous, 1 burst, 2 single, 3 square
//   period        pulse period in clk50 cycles
//   high_time     pulse high width in cycles
//   burst_len     pulses per burst (mode 1)
//   ch_mask       per-channel output enable
//   stim_out      registered stim outputs
//   busy          high while a sequence runs
//   done          one-cycle completion pulse for burst/single sequences
//   pulse_cnt     pulses issued in the current/last sequence (saturating)
// Configuration is latched when start is accepted. One arming cycle follows
// acceptance so that the first pulse appears on the second edge after start.
// -----------------------------------------------------------------------------
module stim_pulse_gen
    import stim_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk50,
    input  logic               rst_n,
    input  logic               stim_en,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   high_time,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [NCH-1:0]     ch_mask,
    output logic [NCH-1:0]     stim_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);

    localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_TWO   = CNT_W'(2);
    localparam logic [BURST_W-1:0] BST_ZERO  = BURST_W'(0);
    localparam logic [BURST_W-1:0] BST_ONE   = BURST_W'(1);
    localparam logic [BURST_W-1:0] BST_MAX   = {BURST_W{1'b1}};
    localparam logic [NCH-1:0]     MASK_ZERO = {NCH{1'b0}};

    stim_state_e        state_r;
    logic               arm_r;
    logic [1:0]         mode_l_r;
    logic [CNT_W-1:0]   period_l_r;
    logic [CNT_W-1:0]   high_l_r;
    logic [BURST_W-1:0] burst_l_r;
    logic [NCH-1:0]     ch_mask_l_r;

    logic [NCH-1:0]     stim_out_r;
    logic               busy_r;
    logic               done_r;
    logic [BURST_W-1:0] pulse_cnt_r;

    logic [CNT_W-1:0]   period_eff_s;
    logic [CNT_W-1:0]   high_eff_s;
    logic [BURST_W-1:0] burst_eff_s;
    logic               cnt_clr_s;
    logic               cnt_en_s;
    logic               wrap_s;
    logic               first_s;
    logic               pulse_raw_s;

    // Clamp the latched configuration into a legal effective period/high/burst.
    always_comb begin
        period_eff_s = period_l_r;
        high_eff_s   = high_l_r;
        burst_eff_s  = burst_l_r;

        if (period_l_r < CNT_TWO) begin
            period_eff_s = CNT_TWO;
        end else begin
            period_eff_s = period_l_r;
        end

        if (mode_l_r == MODE_SQUARE) begin
            high_eff_s = period_eff_s >> 1;
        end else if (high_l_r >= period_eff_s) begin
            high_eff_s = period_eff_s - CNT_ONE;
        end else begin
            high_eff_s = high_l_r;
        end

        if (mode_l_r == MODE_SINGLE) begin
            burst_eff_s = BST_ONE;
        end else if (burst_l_r == BST_ZERO) begin
            burst_eff_s = BST_ONE;
        end else begin
            burst_eff_s = burst_l_r;
        end
    end

    // The phase counter only runs in RUN after the arming cycle.
    always_comb begin
        cnt_clr_s = 1'b1;
        cnt_en_s  = 1'b0;
        if ((state_r == ST_RUN) && !arm_r) begin
            cnt_clr_s = 1'b0;
            cnt_en_s  = 1'b1;
        end else begin
            cnt_clr_s = 1'b1;
            cnt_en_s  = 1'b0;
        end
    end

    stim_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .clr       (cnt_clr_s),
        .en        (cnt_en_s),
        .period    (period_eff_s),
        .high      (high_eff_s),
        .wrap      (wrap_s),
        .first     (first_s),
        .pulse_raw (pulse_raw_s)
    );

    // Sequencer FSM with config latch, pulse counter and registered outputs.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            arm_r       <= 1'b0;
            mode_l_r    <= MODE_CONT;
            period_l_r  <= CNT_ZERO;
            high_l_r    <= CNT_ZERO;
            burst_l_r   <= BST_ZERO;
            ch_mask_l_r <= MASK_ZERO;
            stim_out_r  <= MASK_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pulse_cnt_r <= BST_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stim_out_r <= MASK_ZERO;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    arm_r      <= 1'b0;
                    // stim_en low also wins over a simultaneous start.
                    if (start && stim_en) begin
                        mode_l_r    <= mode;
                        period_l_r  <= period;
                        high_l_r    <= high_time;
                        burst_l_r   <= burst_len;
                        ch_mask_l_r <= ch_mask;
                        pulse_cnt_r <= BST_ZERO;
                        busy_r      <= 1'b1;
                        arm_r       <= 1'b1;
                        state_r     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    done_r <= 1'b0;
                    arm_r  <= 1'b0;
                    if (!stim_en) begin
                        // Abort: no done, pulse count is kept for inspection.
                        stim_out_r <= MASK_ZERO;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        stim_out_r <= pulse_raw_s ? ch_mask_l_r : MASK_ZERO;
                        if (first_s && (pulse_cnt_r != BST_MAX)) begin
                            pulse_cnt_r <= pulse_cnt_r + BST_ONE;
                        end
                        // Count is already updated for this period when its last phase arrives.
                        if (wrap_s && is_counted_mode(mode_l_r) &&
                            (pulse_cnt_r == burst_eff_s)) begin
                            stim_out_r <= MASK_ZERO;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    stim_out_r <= MASK_ZERO;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    arm_r      <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    stim_out_r <= MASK_ZERO;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    arm_r      <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign stim_out  = stim_out_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pulse_cnt = pulse_cnt_r;

endmodule

// File: doc/stim_pulse_gen.md
Name: stim_pulse_gen

Overview:
- Parametrised, multi-channel successor to the fixed divide-by-256 ASIC stimulus generator.
- Produces programmable-period, programmable-width test pulses on NCH ASIC stim lines.
- Modes: continuous, counted burst, single shot and 50 % square.
- Sits between the register/command interface and the ASIC stim pins, in the clk50 domain.

Parameters:
NCH, 4, number of stim output channels
CNT_W, 16, width of period/high-time counters
BURST_W, 8, width of burst length and pulse counter

Ports:
clk50  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
stim_en  in  1  master enable; low forces abort and outputs low
start  in  1  one-cycle request to begin a sequence
mode  in  2  0=continuous, 1=burst, 2=single, 3=square
period  in  CNT_W  pulse period in clk50 cycles
high_time  in  CNT_W  pulse high width in cycles
burst_len  in  BURST_W  pulses per burst (mode 1)
ch_mask  in  NCH  per-channel output enable
stim_out  out  NCH  registered ASIC stim outputs
busy  out  1  high while a sequence runs
done  out  1  one-cycle pulse when a burst/single sequence completes
pulse_cnt  out  BURST_W  pulses issued in current/last sequence

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk50. On reset, stim_out=0, busy=0, done=0, pulse_cnt=0, FSM=IDLE, counters=0.
- FSM states:
  - IDLE -> RUN on start=1 && stim_en=1.
  - RUN -> DONE on sequence complete (modes 1/2).
  - RUN -> IDLE on stim_en=0.
  - DONE -> IDLE after one cycle.
- Config latch: mode, period, high_time, burst_len and ch_mask are latched on the start edge. Later input changes have no effect until the next start.
- Clamping, applied to latched values:
  - period<2 is used as 2.
  - high_time>=period is used as period-1.
  - burst_len=0 is used as 1.
  - Mode 3 ignores high_time and uses floor(period/2).
- Phase counter: runs 0..period-1 and wraps. Raw pulse = (phase < high_eff). The first pulse starts at phase 0.
- Latency: stim_out first rises on the 2nd clk50 edge after the edge sampling start. stim_out[k] = raw & ch_mask_l[k], registered.
- high_time=0 (mode != 3): outputs stay low, but periods are counted and pulse_cnt increments as normal.
- pulse_cnt: cleared on start; increments at each phase wrap to 0 that begins a pulse; saturates at all-ones.
- Mode termination:
  - Mode 0 and mode 3 run until stim_en=0; done is never asserted.
  - Mode 1 ends when phase=period-1 in the period of pulse burst_len.
  - Mode 2 behaves as mode 1 with burst_len=1.
- DONE: stim_out=0, done=1 for exactly one cycle, busy=0.
- busy: 1 in RUN only.
- start while busy: ignored, no restart.
- start while stim_en=0: ignored.
- stim_en deasserted mid-sequence: next edge gives stim_out=0, busy=0 and FSM=IDLE. done is not asserted; pulse_cnt holds its value.
- Simultaneous start and stim_en falling edge: stim_en dominates and the block stays IDLE.
- All arithmetic is unsigned. Comparisons are done at CNT_W width with no overflow beyond CNT_W.

Decomposition:
- Shared package stim_pkg holds:
  - mode encodings MODE_CONT, MODE_BURST, MODE_SINGLE, MODE_SQUARE;
  - FSM state encoding ST_IDLE, ST_RUN, ST_DONE.
- One natural sub-module, stim_phase_cnt: a CNT_W phase counter with clear, enable, period input, a wrap flag and the raw pulse compare. The top holds the FSM, config latch, channel mask and pulse counter.

Test Plan:
- Reset mid-RUN (mode 0, period=10): assert rst_n=0 -> stim_out=0, busy=0 and pulse_cnt=0 immediately (async), before the next clk50 edge.
- Mode 0, period=10, high_time=3, ch_mask=4'b0101: stim_out[0] and [2] are 3 high / 7 low repeating, [1] and [3] stay 0; first rise 2 edges after start.
- Mode 1, period=8, high_time=2, burst_len=5: exactly 5 pulses; done=1 for one cycle 40 cycles after RUN entry; pulse_cnt=5; busy falls.
- Clamping:
  - period=1, high_time=7 -> effective period 2, high 1, giving an alternating 1/0 output.
  - burst_len=0 -> one pulse then done.
- Mode 2 with a second start issued mid-pulse: the second start is ignored; exactly one pulse is produced, followed by one done.
- Mode 3, period=9; drop stim_en after 3 periods: output high 4 / low 5; stim_out goes to 0 on the next edge; no done; pulse_cnt=3.
